// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access-size codes, FSM states, latched request.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package load_store_unit_pkg;

    localparam int LSU_DATA_W = 32;

    // Access size codes carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // Request fields captured at acceptance; the datapath may change its inputs afterwards.
    typedef struct packed {
        logic [1:0]            size;
        logic                  sgn;
        logic [1:0]            lane;
        logic [LSU_DATA_W-1:0] wdata;
    } req_t;

    // Force the byte-lane index onto the natural boundary of the access size.
    // Any size code other than byte/half is handled as a word.
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return lane;
            SZ_HALF: return {lane[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side; no backpressure on responses.
// master: the load/store unit (drives memory port and responses).
// slave : the environment (datapath request side plus data memory read data).
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_we, mem_wd
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_we, mem_wd
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane steering: extracts and sign/zero-extends load lanes; merges store lanes into a read word.
// Latency: combinational.
// Backpressure: none.
// Ports: rd_word (word read from memory), wdata (right-justified store data), size, sgn, lane
//        (already size-aligned byte index) -> ld_data (extended load), st_word (merged store word).
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rd_word[{lane, 3'b000} +: 8];
        half_v  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = rd_word;
        st_word = wdata;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & byte_v[7]}}, byte_v};
                st_word = rd_word;
                st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & half_v[15]}}, half_v};
                st_word = rd_word;
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
            end
            default: begin
                ld_data = rd_word;
                st_word = wdata;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory requester: byte/half/word loads with extension, sub-word stores via read-modify-write.
// Latency from accept edge: load 2, word store 2, sub-word store 3 cycles to resp_valid.
// Backpressure: req_ready only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.master: req_*, resp_*, mem_*).
// Option: LSU_MISALIGN_TRAP_EN -- misaligned half/word requests respond with resp_err=1 and
//         no memory access; otherwise the low address bits are forced to alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master bus
);
    lsu_state_e        state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              misalign;
    logic              is_word;
    logic [DATA_W-1:0] ld_data, st_word;

    load_store_unit_align u_align (
        .rd_word (bus.mem_rd),
        .wdata   (req_q.wdata),
        .size    (req_q.size),
        .sgn     (req_q.sgn),
        .lane    (req_q.lane),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        is_word = (bus.req_size != SZ_BYTE) && (bus.req_size != SZ_HALF);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   (is_word && (bus.req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        mem_address_d = mem_address_q;
        mem_wd_d      = mem_wd_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.size    = bus.req_size;
                    req_d.sgn     = bus.req_signed;
                    req_d.lane    = align_lane(bus.req_size, bus.req_addr[1:0]);
                    req_d.wdata   = bus.req_wdata;
                    err_d         = misalign;
                    if (misalign) begin
                        // Trap: respond without touching memory or the load result.
                        state_d = ST_RESP;
                    end else begin
                        mem_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (!bus.req_write) begin
                            state_d = ST_LOAD;
                        end else if (is_word) begin
                            mem_wd_d = bus.req_wdata;
                            state_d  = ST_WRITE;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = ld_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                // The merged word is the RMW buffer; it is written out unchanged next cycle.
                mem_wd_d = st_word;
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            mem_address_q <= mem_address_d;
            mem_wd_q      <= mem_wd_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    // mem_we comes straight from state so an async reset drops it immediately.
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.mem_we      = (state_q == ST_WRITE);
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wd      = mem_wd_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide behavioural data memory.
// Latency: n/a.
// Backpressure: requests are only driven when req_ready is sampled high.
module tb_load_store_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   we_total;

    logic [31:0] mem [0:16383];
    logic        pre_en;
    logic [13:0] pre_idx;
    logic [31:0] pre_val;

    load_store_unit_if #(.ADDR_W(16)) bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rd = mem[bus.mem_address[15:2]];

    always @(posedge clk) begin
        if (pre_en)           mem[pre_idx] <= pre_val;
        else if (bus.mem_we)  mem[bus.mem_address[15:2]] <= bus.mem_wd;
        if (bus.mem_we) we_total <= we_total + 1;
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = a[15:2]; pre_val = v;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issue one request and observe it until resp_valid (or a bounded number of cycles).
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd,
                         output logic rdy0, output int lat, output logic [31:0] rd,
                         output logic er, output int wen, output logic [15:0] a1,
                         output logic rdy_resp);
        lat = 0; wen = 0; rd = 'x; er = 'x; a1 = 'x; rdy_resp = 'x;
        @(negedge clk);
        rdy0 = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_write = ~wr; bus.req_size = 2'b11;
        bus.req_signed = ~sg; bus.req_addr = 16'h5555; bus.req_wdata = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) a1 = bus.mem_address;
            if (bus.mem_we) wen++;
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err; rdy_resp = bus.req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_address !== 16'h0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", bus.mem_address); end
        checks++; if (bus.mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd got=%h exp=0", bus.mem_wd); end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        preload(16'h0010, 32'h8899AABB);
        issue(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL ld_b_ready got=%b exp=1", r0); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_b_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL ld_b_signed got=%h exp=ffffffaa", rd); end
        checks++; if (a1 !== 16'h0010) begin errors++; $display("FAIL ld_b_addr got=%h exp=0010", a1); end
        checks++; if (wen !== 0) begin errors++; $display("FAIL ld_b_no_write got=%0d exp=0", wen); end
        checks++; if (rr !== 1'b0) begin errors++; $display("FAIL ld_resp_ready got=%b exp=0", rr); end
        issue(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (rd !== 32'h00008899) begin errors++; $display("FAIL ld_h_unsigned got=%h exp=00008899", rd); end
        issue(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL ld_h_signed got=%h exp=ffff8899", rd); end
        issue(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL ld_b_unsigned got=%h exp=00000088", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err got=%b exp=0", er); end
    endtask

    task automatic test_store_sub();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        issue(1'b1, 2'b00, 1'b0, 16'h0012, 32'hFFFFFF5C, r0, lat, rd, er, wen, a1, rr);
        checks++; if (lat !== 3) begin errors++; $display("FAIL st_b_latency got=%0d exp=3", lat); end
        checks++; if (wen !== 1) begin errors++; $display("FAIL st_b_we_pulses got=%0d exp=1", wen); end
        checks++; if (mem[4] !== 32'h885CAABB) begin errors++; $display("FAIL st_b_merge got=%h exp=885caabb", mem[4]); end
        checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL st_rdata_held got=%h exp=00000088", rd); end
        issue(1'b1, 2'b01, 1'b0, 16'h0010, 32'hABCD1234, r0, lat, rd, er, wen, a1, rr);
        checks++; if (wen !== 1) begin errors++; $display("FAIL st_h_we_pulses got=%0d exp=1", wen); end
        checks++; if (mem[4] !== 32'h885C1234) begin errors++; $display("FAIL st_h_merge got=%h exp=885c1234", mem[4]); end
    endtask

    task automatic test_store_word();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        issue(1'b1, 2'b10, 1'b0, 16'h0020, 32'hDEADBEEF, r0, lat, rd, er, wen, a1, rr);
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_w_latency got=%0d exp=2", lat); end
        checks++; if (wen !== 1) begin errors++; $display("FAIL st_w_we_pulses got=%0d exp=1", wen); end
        checks++; if (a1 !== 16'h0020) begin errors++; $display("FAIL st_w_addr got=%h exp=0020", a1); end
        issue(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL st_w_readback got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_wrap();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        preload(16'hFFFC, 32'h7F000000);
        issue(1'b0, 2'b00, 1'b1, 16'hFFFF, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (a1 !== 16'hFFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffc", a1); end
        checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL wrap_byte got=%h exp=0000007f", rd); end
    endtask

    task automatic test_back_to_back();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        issue(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (rd !== 32'h885C1234) begin errors++; $display("FAIL b2b_first got=%h exp=885c1234", rd); end
        issue(1'b0, 2'b00, 1'b0, 16'h0010, 32'h0, r0, lat, rd, er, wen, a1, rr);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp got=%b exp=1", r0); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h00000034) begin errors++; $display("FAIL b2b_second got=%h exp=00000034", rd); end
    endtask

    task automatic test_misalign();
        logic r0, er, rr; int lat, wen; logic [31:0] rd; logic [15:0] a1;
        issue(1'b0, 2'b10, 1'b0, 16'h0013, 32'h0, r0, lat, rd, er, wen, a1, rr);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got=%0d exp=1", lat); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err got=%b exp=1", er); end
        checks++; if (wen !== 0) begin errors++; $display("FAIL mis_no_access got=%0d exp=0", wen); end
        checks++; if (rd !== 32'h00000034) begin errors++; $display("FAIL mis_rdata_kept got=%h exp=00000034", rd); end
`else
        checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_err got=%b exp=0", er); end
        checks++; if (a1 !== 16'h0010) begin errors++; $display("FAIL mis_addr got=%h exp=0010", a1); end
        checks++; if (rd !== 32'h885C1234) begin errors++; $display("FAIL mis_rdata got=%h exp=885c1234", rd); end
`endif
    endtask

    task automatic test_reset_mid_rmw();
        int we_before;
        preload(16'h0030, 32'h11223344);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 16'h0032; bus.req_wdata = 32'h0000AAAA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        we_before = we_total;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmw_rst_we got=%b exp=0", bus.mem_we); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (we_total !== we_before) begin errors++; $display("FAIL rmw_rst_no_write got=%0d exp=%0d", we_total, we_before); end
        checks++; if (mem[12] !== 32'h11223344) begin errors++; $display("FAIL rmw_rst_word got=%h exp=11223344", mem[12]); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmw_rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rmw_rst_resp got=%b exp=0", bus.resp_valid); end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; errors = 0; checks = 0; we_total = 0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_load();
        test_store_sub();
        test_store_word();
        test_wrap();
        test_back_to_back();
        test_misalign();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
